// File: rtl/vga_pkg.sv
//============================================================================
// Module      : vga_pkg
// Description : XGA 1024x768@60 Hz default raster constants and count type.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_COUNT_W  = 12;

    localparam int c_H_ACTIVE = 1024;
    localparam int c_H_FP     = 24;
    localparam int c_H_SYNC   = 136;
    localparam int c_H_BP     = 160;
    localparam int c_V_ACTIVE = 768;
    localparam int c_V_FP     = 3;
    localparam int c_V_SYNC   = 6;
    localparam int c_V_BP     = 29;

    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    typedef logic [c_COUNT_W-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_wrap_counter.sv
//============================================================================
// Module      : wrap_counter
// Description : Enabled up-counter that wraps to zero on an equality compare
//               with TERMINAL; exposes its next value for flag pre-decode.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wrap_counter
    import vga_pkg::*;
#(
    parameter int               WIDTH    = c_COUNT_W,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == TERMINAL);

    always_comb begin
        o_next = r_count;
        if (i_en) begin
            o_next = w_tc ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;
    assign o_tc    = w_tc;

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
//============================================================================
// Module      : vga_timing
// Description : Free-running raster timing generator (counts, syncs, blanks,
//               frame-start strobe). VGA_SYNC_ACTIVE_LOW_EN selects low-true
//               hsync/vsync.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [11:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [11:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_start
);

    localparam count_t c_H_LAST   = count_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam count_t c_H_BLANK  = count_t'(H_ACTIVE);
    localparam count_t c_HS_FIRST = count_t'(H_ACTIVE + H_FP);
    localparam count_t c_HS_LAST  = count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam count_t c_V_LAST   = count_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam count_t c_V_BLANK  = count_t'(V_ACTIVE);
    localparam count_t c_VS_FIRST = count_t'(V_ACTIVE + V_FP);
    localparam count_t c_VS_LAST  = count_t'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic c_SYNC_ON = 1'b0;
`else
    localparam logic c_SYNC_ON = 1'b1;
`endif

    count_t w_h_next;
    count_t w_v_next;
    logic   w_h_tc;
    logic   w_v_tc;

    logic   r_hsync;
    logic   r_hblnk;
    logic   r_vsync;
    logic   r_vblnk;
    logic   r_frame_start;

    wrap_counter #(
        .WIDTH    (c_COUNT_W),
        .TERMINAL (c_H_LAST)
    ) u_hcnt (
        .clk     (pclk),
        .rst     (rst),
        .i_en    (1'b1),
        .o_count (hcount),
        .o_next  (w_h_next),
        .o_tc    (w_h_tc)
    );

    // The line counter only moves on the last pixel of a line.
    wrap_counter #(
        .WIDTH    (c_COUNT_W),
        .TERMINAL (c_V_LAST)
    ) u_vcnt (
        .clk     (pclk),
        .rst     (rst),
        .i_en    (w_h_tc),
        .o_count (vcount),
        .o_next  (w_v_next),
        .o_tc    (w_v_tc)
    );

    // Flags decode the counters' next values so they land on the same edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hsync       <= ~c_SYNC_ON;
            r_hblnk       <= 1'b0;
            r_vsync       <= ~c_SYNC_ON;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hblnk       <= (w_h_next >= c_H_BLANK);
            r_hsync       <= ((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST))
                             ? c_SYNC_ON : ~c_SYNC_ON;
            r_vblnk       <= (w_v_next >= c_V_BLANK);
            r_vsync       <= ((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST))
                             ? c_SYNC_ON : ~c_SYNC_ON;
            r_frame_start <= w_h_tc & w_v_tc;
        end
    end

    assign hsync       = r_hsync;
    assign hblnk       = r_hblnk;
    assign vsync       = r_vsync;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
//============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing: a full XGA instance for
//               line timing and a reduced-raster instance for frame timing.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic        fs;
    } bundle_t;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic c_SYNC_ON = 1'b0;
`else
    localparam logic c_SYNC_ON = 1'b1;
`endif

    localparam int c_F_HT = 1344;
    localparam int c_S_HT = 17;
    localparam int c_S_VT = 12;
    localparam int c_S_FRAME = c_S_HT * c_S_VT;

    logic pclk = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;

    logic [11:0] hc_f, vc_f, hc_s, vc_s;
    logic hs_f, hb_f, vs_f, vb_f, fs_f;
    logic hs_s, hb_s, vs_s, vb_s, fs_s;
    bundle_t act_f, act_s;

    longint n_f = 0;
    longint n_s = 0;
    bit     inr_f = 1'b1;
    bit     inr_s = 1'b1;
    int     n_checks = 0;
    int     n_pass = 0;

    always #5 pclk = ~pclk;

    vga_timing dut_f (
        .pclk(pclk), .rst(rst_f), .hcount(hc_f), .hsync(hs_f), .hblnk(hb_f),
        .vcount(vc_f), .vsync(vs_f), .vblnk(vb_f), .frame_start(fs_f)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .pclk(pclk), .rst(rst_s), .hcount(hc_s), .hsync(hs_s), .hblnk(hb_s),
        .vcount(vc_s), .vsync(vs_s), .vblnk(vb_s), .frame_start(fs_s)
    );

    assign act_f = {hc_f, vc_f, hs_f, hb_f, vs_f, vb_f, fs_f};
    assign act_s = {hc_s, vc_s, hs_s, hb_s, vs_s, vb_s, fs_s};

    // Raster position is a pure function of edges counted since reset.
    function automatic bundle_t ref_at(input longint n, input bit in_rst,
                                       input int ha, input int hf, input int hsw, input int hbp,
                                       input int va, input int vf, input int vsw, input int vbp);
        bundle_t b;
        longint ht = longint'(ha + hf + hsw + hbp);
        longint vt = longint'(va + vf + vsw + vbp);
        longint h  = n % ht;
        longint v  = (n / ht) % vt;
        b.h  = 12'(h);
        b.v  = 12'(v);
        b.hb = !in_rst && (h >= ha);
        b.vb = !in_rst && (v >= va);
        b.hs = (!in_rst && h >= ha + hf && h < ha + hf + hsw) ? c_SYNC_ON : ~c_SYNC_ON;
        b.vs = (!in_rst && v >= va + vf && v < va + vf + vsw) ? c_SYNC_ON : ~c_SYNC_ON;
        b.fs = !in_rst && (h == 0) && (v == 0);
        return b;
    endfunction

    function automatic bundle_t ref_f();
        return ref_at(n_f, inr_f, 1024, 24, 136, 160, 768, 3, 6, 29);
    endfunction

    function automatic bundle_t ref_s();
        return ref_at(n_s, inr_s, 8, 2, 3, 4, 6, 1, 2, 3);
    endfunction

    task automatic step_f(input logic r);
        rst_f = r;
        @(posedge pclk);
        if (r) begin n_f = 0; inr_f = 1'b1; end
        else   begin n_f++;   inr_f = 1'b0; end
        #1;
    endtask

    task automatic step_s(input logic r);
        rst_s = r;
        @(posedge pclk);
        if (r) begin n_s = 0; inr_s = 1'b1; end
        else   begin n_s++;   inr_s = 1'b0; end
        #1;
    endtask

    task automatic test_reset();
        bundle_t e;
        for (int i = 0; i < 5; i++) begin
            step_f(1'b1);
            e = ref_f();
            n_checks++;
            if (act_f !== e || act_f.fs !== 1'b0 || act_f.h !== 12'd0)
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, act_f, e);
            else n_pass++;
        end
        for (int i = 1; i <= 3; i++) begin
            step_f(1'b0);
            e = ref_f();
            n_checks++;
            if (act_f !== e || act_f.h !== 12'(i) || act_f.v !== 12'd0)
                $display("FAIL reset_release edge %0d: got %h want %h", i, act_f, e);
            else n_pass++;
        end
    endtask

    task automatic test_line_wrap();
        bundle_t e;
        while (n_f < longint'(c_F_HT - 1)) begin
            step_f(1'b0);
            e = ref_f();
            n_checks++;
            if (act_f !== e) $display("FAIL line0_run n=%0d: got %h want %h", n_f, act_f, e);
            else n_pass++;
        end
        n_checks++;
        if (act_f.h !== 12'd1343 || act_f.hb !== 1'b1)
            $display("FAIL line_wrap_pre: got h=%0d hb=%b want h=1343 hb=1", act_f.h, act_f.hb);
        else n_pass++;
        step_f(1'b0);
        e = ref_f();
        n_checks++;
        if (act_f !== e || act_f.h !== 12'd0 || act_f.v !== 12'd1 || act_f.hb !== 1'b0)
            $display("FAIL line_wrap: got %h want %h", act_f, e);
        else n_pass++;
    endtask

    task automatic test_hwindows();
        bundle_t e;
        logic    prev_hb = 1'b0;
        logic    prev_hs = ~c_SYNC_ON;
        while (n_f < longint'(11 * c_F_HT)) begin
            step_f(1'b0);
            e = ref_f();
            n_checks++;
            if (act_f !== e) $display("FAIL hwin_run n=%0d: got %h want %h", n_f, act_f, e);
            else n_pass++;
            if (e.v == 12'd10 && e.h == 12'd1024) begin
                n_checks++;
                if (act_f.hb !== 1'b1 || prev_hb !== 1'b0)
                    $display("FAIL hblnk_rise: got %b->%b want 0->1", prev_hb, act_f.hb);
                else n_pass++;
            end
            if (e.v == 12'd10 && e.h == 12'd1048) begin
                n_checks++;
                if (act_f.hs !== c_SYNC_ON || prev_hs !== ~c_SYNC_ON)
                    $display("FAIL hsync_on: got %b->%b want %b->%b", prev_hs, act_f.hs, ~c_SYNC_ON, c_SYNC_ON);
                else n_pass++;
            end
            if (e.v == 12'd10 && e.h == 12'd1184) begin
                n_checks++;
                if (act_f.hs !== ~c_SYNC_ON || prev_hs !== c_SYNC_ON)
                    $display("FAIL hsync_off: got %b->%b want %b->%b", prev_hs, act_f.hs, c_SYNC_ON, ~c_SYNC_ON);
                else n_pass++;
            end
            prev_hb = act_f.hb;
            prev_hs = act_f.hs;
        end
    endtask

    task automatic test_mid_reset();
        bundle_t e;
        while (n_f < longint'(12 * c_F_HT + 500)) begin
            step_f(1'b0);
            e = ref_f();
            n_checks++;
            if (act_f !== e) $display("FAIL midrst_run n=%0d: got %h want %h", n_f, act_f, e);
            else n_pass++;
        end
        step_f(1'b1);
        e = ref_f();
        n_checks++;
        if (act_f !== e || act_f.h !== 12'd0 || act_f.v !== 12'd0 || act_f.hs !== ~c_SYNC_ON)
            $display("FAIL mid_reset: got %h want %h", act_f, e);
        else n_pass++;
        step_f(1'b0);
        e = ref_f();
        n_checks++;
        if (act_f !== e || act_f.h !== 12'd1 || act_f.v !== 12'd0)
            $display("FAIL mid_reset_release: got %h want %h", act_f, e);
        else n_pass++;
    endtask

    task automatic test_vwindows();
        bundle_t e;
        int      vs_cnt = 0;
        int      vb_cnt = 0;
        step_s(1'b1);
        step_s(1'b1);
        for (int i = 0; i < 2 * c_S_FRAME; i++) begin
            step_s(1'b0);
            e = ref_s();
            n_checks++;
            if (act_s !== e) $display("FAIL vwin_run n=%0d: got %h want %h", n_s, act_s, e);
            else n_pass++;
            if (i < c_S_FRAME) begin
                if (act_s.vs === c_SYNC_ON) vs_cnt++;
                if (act_s.vb === 1'b1) vb_cnt++;
            end
        end
        n_checks++;
        if (vs_cnt != 2 * c_S_HT) $display("FAIL vsync_cycles: got %0d want %0d", vs_cnt, 2 * c_S_HT);
        else n_pass++;
        n_checks++;
        if (vb_cnt != 6 * c_S_HT) $display("FAIL vblnk_cycles: got %0d want %0d", vb_cnt, 6 * c_S_HT);
        else n_pass++;
    endtask

    task automatic test_frame_period();
        int steps = 0;
        int highs = 0;
        int pulses = 0;
        int last = 0;
        step_s(1'b1);
        step_s(1'b0);
        steps = 1;
        while (pulses < 4 && steps < 6 * c_S_FRAME) begin
            if (act_s.fs === 1'b1) begin
                highs++;
                n_checks++;
                if (pulses == 0) begin
                    if (steps - 1 != c_S_FRAME - 1)
                        $display("FAIL first_frame_start: got %0d want %0d", steps - 1, c_S_FRAME - 1);
                    else n_pass++;
                end else begin
                    if (steps - last != c_S_FRAME)
                        $display("FAIL frame_period: got %0d want %0d", steps - last, c_S_FRAME);
                    else n_pass++;
                end
                pulses++;
                last = steps;
            end
            step_s(1'b0);
            steps++;
        end
        n_checks++;
        if (pulses != 4) $display("FAIL frame_start_timeout: got %0d pulses want 4", pulses);
        else n_pass++;
        n_checks++;
        if (highs != pulses) $display("FAIL frame_start_width: got %0d high cycles want %0d", highs, pulses);
        else n_pass++;
    endtask

    task automatic test_random_reset();
        bundle_t e;
        int      len;
        int      rl;
        for (int k = 0; k < 8; k++) begin
            len = int'($urandom_range(0, 3 * c_S_FRAME));
            for (int i = 0; i < len; i++) begin
                step_s(1'b0);
                e = ref_s();
                n_checks++;
                if (act_s !== e) $display("FAIL rnd_run n=%0d: got %h want %h", n_s, act_s, e);
                else n_pass++;
            end
            rl = int'($urandom_range(1, 3));
            for (int i = 0; i < rl; i++) begin
                step_s(1'b1);
                e = ref_s();
                n_checks++;
                if (act_s !== e) $display("FAIL rnd_reset: got %h want %h", act_s, e);
                else n_pass++;
            end
            step_s(1'b0);
            e = ref_s();
            n_checks++;
            if (act_s !== e || act_s.h !== 12'd1 || act_s.v !== 12'd0)
                $display("FAIL rnd_release: got %h want %h", act_s, e);
            else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_line_wrap();
        test_hwindows();
        test_mid_reset();
        test_vwindows();
        test_frame_period();
        test_random_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Free-running XGA raster timing generator at the head of the video pipeline: produces horizontal/vertical pixel counts, sync and blanking strobes for 1024x768@60 Hz on a 65 MHz pixel clock. Its outputs drive the background-drawing stage directly, and every later overlay stage consumes the same bundle delayed. It also emits a one-cycle frame-start strobe for frame-synchronous logic such as sample latching for the voltage readout.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)

Ports:
- pclk  in  1  pixel clock, 65 MHz
- rst  in  1  reset, synchronous, active-high
- hcount  out  12  horizontal position, 0..H_TOTAL-1
- hsync  out  1  horizontal sync
- hblnk  out  1  horizontal blanking
- vcount  out  12  vertical position, 0..V_TOTAL-1
- vsync  out  1  vertical sync
- vblnk  out  1  vertical blanking
- frame_start  out  1  one-cycle strobe at raster position (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- hcount increments every pclk. At H_TOTAL-1 it wraps to 0 and vcount advances. vcount wraps to 0 from V_TOTAL-1 when hcount also wraps.
- hblnk = 1 for hcount in [H_ACTIVE, H_TOTAL-1] (1024..1343).
- hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (1048..1183).
- vblnk = 1 for vcount in [V_ACTIVE, V_TOTAL-1] (768..805), for every hcount on those lines.
- vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (771..776), for every hcount on those lines.
- frame_start = 1 exactly when the outputs show hcount=0 and vcount=0, but not while in reset.
- Counter arithmetic is 12-bit unsigned. Wrap uses an explicit equality compare, not overflow.
- All outputs are registered. Flags are decoded from the next-state counts so that they stay aligned with the registered counts.

## Timing
- Reset value: hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0. hsync and vsync are driven to their inactive level (see Configuration).
- During rst the block holds its reset state. rst asserted mid-frame takes effect on the next edge, with no partial-line completion.
- First edge with rst low: hcount=1, vcount=0, with flags decoded for (1,0).
- The first frame_start after reset release occurs H_TOTAL*V_TOTAL-1 = 1083263 cycles after that first edge. It then repeats every 1083264 cycles.
- Output latency relative to internal count: 0. All outputs change on the same edge, with no skew between counts and flags.
- Simultaneous wrap at (1343,805) goes to (0,0), and frame_start rises on that same edge.

## Configuration
- Macro VGA_SYNC_ACTIVE_LOW_EN.
- Defined: hsync/vsync are 0 inside their sync windows and 1 otherwise; the reset value of hsync/vsync is 1.
- Undefined: hsync/vsync are 1 inside their sync windows and 0 otherwise; the reset value is 0.
- Blanking flags and frame_start are active-high in both builds.

## Structure
- Shared package vga_pkg holds the default timing constants (the eight parameter values), the derived H_TOTAL/V_TOTAL, and the count width (12).
- One sub-module is natural: wrap_counter, a parameterised 12-bit counter with enable, synchronous reset and terminal-count output. It is instantiated twice, with the horizontal terminal count enabling the vertical counter.

## Test plan
- Reset/release: hold rst for 5 cycles. Expect all outputs at their reset values. After release, expect hcount to read 1,2,3 on successive edges and vcount=0.
- Line wrap: run to hcount=1343 (vcount=0), then one edge. Expect hcount=0 and vcount=1, with hblnk falling 1→0 on that edge.
- Horizontal windows: on line 10, expect hblnk to rise at hcount=1024, hsync to go active at 1048 and inactive at 1184, and hblnk to stay 1 through 1343.
- Vertical windows: expect vblnk=1 from vcount=768 through 805, vsync active for vcount 771..776 only, and vblnk=0 at vcount=0.
- Frame period: expect frame_start high for exactly one cycle at (0,0). The next assertion follows 1083264 cycles later, and there are no other pulses.
- Mid-frame reset: assert rst at (500,400) for 1 cycle. Expect (0,0) with reset values on the following edge, then (1,0) afterwards. Repeat this check with the VGA_SYNC_ACTIVE_LOW_EN build, expecting inverted sync levels.
